// File: rtl/rx_gearbox_pkg.sv
// Shared definitions for the receive gearbox: FSM states, preamble/SFD
// patterns and the end-of-frame byte-count encoding.
package rx_gearbox_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PREAMBLE = 2'd1,
      ST_DATA     = 2'd2,
      ST_DROP     = 2'd3
   } state_t;

   localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0] SFD_BYTE      = 8'hD5;
   localparam logic [3:0] PREAMBLE_NIB  = 4'h5;
   localparam logic [3:0] SFD_NIB       = 4'hD;

   // Valid bytes in the eop word; a full word encodes as zero
   localparam logic [1:0] MOD_4 = 2'b00;
   localparam logic [1:0] MOD_1 = 2'b01;
   localparam logic [1:0] MOD_2 = 2'b10;
   localparam logic [1:0] MOD_3 = 2'b11;

   // Map the number of bytes held in a partial word onto the mod code
   function automatic logic [1:0] cnt_to_mod(input logic [1:0] cnt);
      case (cnt)
         2'd1:    return MOD_1;
         2'd2:    return MOD_2;
         2'd3:    return MOD_3;
         default: return MOD_4;
      endcase
   endfunction

   // GMII DDR capture delivers the byte with its nibbles exchanged
   function automatic logic [7:0] nibble_swap(input logic [7:0] d);
      return {d[3:0], d[7:4]};
   endfunction

endpackage

// File: rtl/rx_gearbox_if.sv
// Word-stream output bus of the receive gearbox.
interface rx_gearbox_if;

   logic [31:0] int_data_o;
   logic        int_valid_o;
   logic        int_sop_o;
   logic        int_eop_o;
   logic [1:0]  int_mod_o;
   logic        int_err_o;

   modport master (
      output int_data_o, int_valid_o, int_sop_o, int_eop_o, int_mod_o, int_err_o
   );

   modport slave (
      input  int_data_o, int_valid_o, int_sop_o, int_eop_o, int_mod_o, int_err_o
   );

endinterface

// File: rtl/rx_byte_assembler.sv
// Turns the GMII receive lane into a byte stream: a swapped byte per clock in
// giga mode, or two nibbles (low first) per byte in 10/100 mode.
module rx_byte_assembler
   import rx_gearbox_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       i_giga,
   input  logic       i_en,
   input  logic       i_clear,
   input  logic [7:0] i_data,
   output logic [7:0] o_byte,
   output logic       o_byte_vld,
   output logic       o_odd
);

   logic [3:0] r_nib;
   logic       r_phase;

   // Hold the first (low) nibble until its partner arrives; i_clear realigns
   // so the first nibble after the SFD is always treated as a low nibble
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nib   <= 4'h0;
         r_phase <= 1'b0;
      end else if (i_clear) begin
         r_phase <= 1'b0;
      end else if (i_en && !i_giga) begin
         if (!r_phase) begin
            r_nib   <= i_data[3:0];
            r_phase <= 1'b1;
         end else begin
            r_phase <= 1'b0;
         end
      end
   end

   assign o_byte     = i_giga ? nibble_swap(i_data) : {i_data[3:0], r_nib};
   assign o_byte_vld = i_en && !i_clear && (i_giga || r_phase);
   assign o_odd      = r_phase;

endmodule

// File: rtl/rx_gearbox.sv
// GMII / MII receive gearbox: strips preamble and SFD, packs payload bytes
// big-endian into 32-bit words and marks sop/eop/mod/err on the word stream.
module rx_gearbox
   import rx_gearbox_pkg::*;
(
   input  logic          rst,
   input  logic          clk,
   input  logic          phy_giga_mode,
   input  logic          gmii_ctrl,
   input  logic [7:0]    gmii_data,
   rx_gearbox_if.master  rx_out
);

   state_t      r_state;
   logic        r_giga;
   logic        r_ctrl_d;
   logic        r_prev5;
   logic [31:0] r_word;
   logic [1:0]  r_cnt;
   logic [31:0] r_hold;
   logic        r_hold_vld;
   logic        r_first;

   logic [31:0] r_data;
   logic        r_valid;
   logic        r_sop;
   logic        r_eop;
   logic [1:0]  r_mod;
   logic        r_err;

   logic        w_mode;
   logic        w_clear;
   logic [7:0]  w_byte;
   logic        w_byte_vld;
   logic        w_odd;
   logic [3:0]  w_nib;

   // Mode follows the pin while idle and is frozen for the rest of the frame
   assign w_mode  = (r_state == ST_IDLE) ? phy_giga_mode : r_giga;
   assign w_clear = (r_state != ST_DATA);
   assign w_nib   = gmii_data[3:0];

   rx_byte_assembler u_asm (
      .clk        (clk),
      .rst        (rst),
      .i_giga     (w_mode),
      .i_en       (gmii_ctrl),
      .i_clear    (w_clear),
      .i_data     (gmii_data),
      .o_byte     (w_byte),
      .o_byte_vld (w_byte_vld),
      .o_odd      (w_odd)
   );

   // Frame FSM, word packing and registered output strobes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_giga     <= 1'b0;
         // Treat dv as already high so a frame in flight at release is ignored
         r_ctrl_d   <= 1'b1;
         r_prev5    <= 1'b0;
         r_word     <= '0;
         r_cnt      <= '0;
         r_hold     <= '0;
         r_hold_vld <= 1'b0;
         r_first    <= 1'b0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_sop      <= 1'b0;
         r_eop      <= 1'b0;
         r_mod      <= MOD_4;
         r_err      <= 1'b0;
      end else begin
         r_ctrl_d <= gmii_ctrl;
         r_data   <= '0;
         r_valid  <= 1'b0;
         r_sop    <= 1'b0;
         r_eop    <= 1'b0;
         r_mod    <= MOD_4;
         r_err    <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               r_giga <= phy_giga_mode;
               // The first dv beat is taken as preamble; only the 5 of a
               // nibble preamble matters for SFD alignment
               if (gmii_ctrl && !r_ctrl_d) begin
                  r_state <= ST_PREAMBLE;
                  r_prev5 <= (w_nib == PREAMBLE_NIB);
               end
            end

            ST_PREAMBLE: begin
               if (!gmii_ctrl) begin
                  r_state <= ST_IDLE;
               end else if (r_giga) begin
                  if (w_byte == SFD_BYTE) begin
                     r_state    <= ST_DATA;
                     r_word     <= '0;
                     r_cnt      <= '0;
                     r_hold_vld <= 1'b0;
                     r_first    <= 1'b1;
                  end else if (w_byte != PREAMBLE_BYTE) begin
                     r_state <= ST_DROP;
                     r_err   <= 1'b1;
                  end
               end else begin
                  if (w_nib == PREAMBLE_NIB) begin
                     r_prev5 <= 1'b1;
                  end else if (w_nib == SFD_NIB && r_prev5) begin
                     r_state    <= ST_DATA;
                     r_word     <= '0;
                     r_cnt      <= '0;
                     r_hold_vld <= 1'b0;
                     r_first    <= 1'b1;
                  end else begin
                     r_state <= ST_DROP;
                     r_err   <= 1'b1;
                  end
               end
            end

            ST_DATA: begin
               if (!gmii_ctrl) begin
                  r_state    <= ST_IDLE;
                  r_hold_vld <= 1'b0;
                  // A dangling nibble is reported alongside the final word
                  if (r_hold_vld) begin
                     r_data  <= r_hold;
                     r_valid <= 1'b1;
                     r_sop   <= r_first;
                     r_eop   <= 1'b1;
                     r_mod   <= MOD_4;
                     r_err   <= w_odd;
                  end else if (r_cnt != 2'd0) begin
                     r_data  <= r_word;
                     r_valid <= 1'b1;
                     r_sop   <= r_first;
                     r_eop   <= 1'b1;
                     r_mod   <= cnt_to_mod(r_cnt);
                     r_err   <= w_odd;
                  end else begin
                     r_err   <= 1'b1;
                  end
               end else if (w_byte_vld) begin
                  // A full word waits in r_hold until we know it is not the last
                  if (r_hold_vld) begin
                     r_data     <= r_hold;
                     r_valid    <= 1'b1;
                     r_sop      <= r_first;
                     r_first    <= 1'b0;
                     r_hold_vld <= 1'b0;
                  end
                  case (r_cnt)
                     2'd0: begin
                        r_word[31:24] <= w_byte;
                        r_cnt         <= 2'd1;
                     end
                     2'd1: begin
                        r_word[23:16] <= w_byte;
                        r_cnt         <= 2'd2;
                     end
                     2'd2: begin
                        r_word[15:8] <= w_byte;
                        r_cnt        <= 2'd3;
                     end
                     default: begin
                        r_hold     <= {r_word[31:8], w_byte};
                        r_hold_vld <= 1'b1;
                        r_word     <= '0;
                        r_cnt      <= 2'd0;
                     end
                  endcase
               end
            end

            ST_DROP: begin
               if (!gmii_ctrl) begin
                  r_state <= ST_IDLE;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rx_out.int_data_o  = r_data;
   assign rx_out.int_valid_o = r_valid;
   assign rx_out.int_sop_o   = r_sop;
   assign rx_out.int_eop_o   = r_eop;
   assign rx_out.int_mod_o   = r_mod;
   assign rx_out.int_err_o   = r_err;

endmodule

// File: tb/tb_rx_gearbox.sv
// Directed bench for rx_gearbox: giga and 10/100 frames, preamble errors,
// short frames, back-to-back frames and mid-frame reset.
module tb_rx_gearbox;

   logic       clk = 1'b0;
   logic       rst;
   logic       phy_giga_mode;
   logic       gmii_ctrl;
   logic [7:0] gmii_data;

   rx_gearbox_if bus ();

   rx_gearbox dut (
      .rst           (rst),
      .clk           (clk),
      .phy_giga_mode (phy_giga_mode),
      .gmii_ctrl     (gmii_ctrl),
      .gmii_data     (gmii_data),
      .rx_out        (bus)
   );

   always #4 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   // Observed words packed as {data, sop, eop, mod, err}
   logic [36:0] mon_q[$];
   int          err_cnt   = 0;
   int          idle_viol = 0;

   // Record every word strobe and error pulse away from the active edge
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.int_valid_o)
            mon_q.push_back({bus.int_data_o, bus.int_sop_o, bus.int_eop_o,
                             bus.int_mod_o, bus.int_err_o});
         else if (bus.int_data_o != 32'h0 || bus.int_sop_o || bus.int_eop_o ||
                  bus.int_mod_o != 2'b00)
            idle_viol <= idle_viol + 1;
         if (bus.int_err_o)
            err_cnt <= err_cnt + 1;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [36:0] pk(input logic [31:0] d, input logic s, input logic e,
                                      input logic [1:0] m, input logic er);
      return {d, s, e, m, er};
   endfunction

   function automatic logic [7:0] swp(input logic [7:0] b);
      return {b[3:0], b[7:4]};
   endfunction

   task automatic beat(input logic c, input logic [7:0] d);
      gmii_ctrl = c;
      gmii_data = d;
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (3) beat(1'b0, 8'h00);
   endtask

   // Giga frame: preamble, SFD, payload, then one dv-low beat
   task automatic send_giga(input int npre, input logic [7:0] pl[$]);
      for (int i = 0; i < npre; i++) beat(1'b1, swp(8'h55));
      beat(1'b1, swp(8'hD5));
      foreach (pl[i]) beat(1'b1, swp(pl[i]));
      beat(1'b0, 8'h00);
   endtask

   // 10/100 frame: raw nibbles with junk in the upper half, optionally
   // toggling the mode pin after the first nibble
   task automatic send_nib(input logic [3:0] nq[$], input bit flip);
      foreach (nq[i]) begin
         beat(1'b1, {4'hA, nq[i]});
         if (flip && i == 0) phy_giga_mode = 1'b1;
      end
      beat(1'b0, 8'h00);
   endtask

   task automatic chk_frame(input string tag, input int base, input int ebase,
                            input logic [36:0] exp[$], input int exp_err);
      logic [36:0] got;
      chk({tag, "_nwords"}, 64'(mon_q.size() - base), 64'(exp.size()));
      foreach (exp[i]) begin
         got = (base + i < mon_q.size()) ? mon_q[base + i] : '1;
         chk($sformatf("%s_w%0d", tag, i), 64'(got), 64'(exp[i]));
      end
      chk({tag, "_errs"}, 64'(err_cnt - ebase), 64'(exp_err));
   endtask

   initial begin
      logic [7:0]  pl[$];
      logic [3:0]  nq[$];
      logic [36:0] ex[$];
      int b, e;

      rst = 1'b1;
      phy_giga_mode = 1'b1;
      gmii_ctrl = 1'b0;
      gmii_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(bus.int_valid_o), 64'd0);
      chk("rst_data",  64'(bus.int_data_o),  64'd0);
      chk("rst_sop",   64'(bus.int_sop_o),   64'd0);
      chk("rst_eop",   64'(bus.int_eop_o),   64'd0);
      chk("rst_mod",   64'(bus.int_mod_o),   64'd0);
      chk("rst_err",   64'(bus.int_err_o),   64'd0);
      rst = 1'b0;
      drain();

      // Giga 8-byte frame
      b = mon_q.size(); e = err_cnt;
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_giga(7, pl);
      drain();
      ex = '{pk(32'h01020304, 1, 0, 2'b00, 0), pk(32'h05060708, 0, 1, 2'b00, 0)};
      chk_frame("g8", b, e, ex, 0);

      // Giga 5-byte frame, one byte in last word
      b = mon_q.size(); e = err_cnt;
      pl = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
      send_giga(7, pl);
      drain();
      ex = '{pk(32'hAABBCCDD, 1, 0, 2'b00, 0), pk(32'hEE000000, 0, 1, 2'b01, 0)};
      chk_frame("g5", b, e, ex, 0);

      // Giga 2-byte frame
      b = mon_q.size(); e = err_cnt;
      pl = '{8'h9C, 8'h3E};
      send_giga(3, pl);
      drain();
      ex = '{pk(32'h9C3E0000, 1, 1, 2'b10, 0)};
      chk_frame("g2", b, e, ex, 0);

      // 10/100 three-byte frame; mode pin flips mid-frame and must be ignored
      phy_giga_mode = 1'b0;
      drain();
      b = mon_q.size(); e = err_cnt;
      nq = {};
      repeat (15) nq.push_back(4'h5);
      nq.push_back(4'hD);
      nq.push_back(4'h1); nq.push_back(4'h0);
      nq.push_back(4'h2); nq.push_back(4'h0);
      nq.push_back(4'h3); nq.push_back(4'h0);
      send_nib(nq, 1'b1);
      phy_giga_mode = 1'b0;
      drain();
      ex = '{pk(32'h01020300, 1, 1, 2'b11, 0)};
      chk_frame("m3", b, e, ex, 0);

      // 10/100 with dangling nibble: error in the eop cycle
      b = mon_q.size(); e = err_cnt;
      nq = {};
      repeat (15) nq.push_back(4'h5);
      nq.push_back(4'hD);
      nq.push_back(4'h1); nq.push_back(4'h0); nq.push_back(4'h2);
      send_nib(nq, 1'b0);
      drain();
      ex = '{pk(32'h01000000, 1, 1, 2'b01, 1)};
      chk_frame("modd", b, e, ex, 1);

      // 10/100 SFD with no data: error only
      b = mon_q.size(); e = err_cnt;
      nq = {};
      repeat (7) nq.push_back(4'h5);
      nq.push_back(4'hD);
      send_nib(nq, 1'b0);
      drain();
      ex = {};
      chk_frame("mempty", b, e, ex, 1);

      // Giga bad preamble byte, then a good frame
      phy_giga_mode = 1'b1;
      drain();
      b = mon_q.size(); e = err_cnt;
      beat(1'b1, swp(8'h55));
      beat(1'b1, swp(8'h55));
      beat(1'b1, swp(8'h12));
      beat(1'b1, swp(8'h34));
      beat(1'b0, 8'h00);
      drain();
      ex = {};
      chk_frame("gbad", b, e, ex, 1);
      b = mon_q.size(); e = err_cnt;
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_giga(7, pl);
      drain();
      ex = '{pk(32'h01020304, 1, 0, 2'b00, 0), pk(32'h05060708, 0, 1, 2'b00, 0)};
      chk_frame("gafter", b, e, ex, 0);

      // dv drops during preamble: silently abandoned
      b = mon_q.size(); e = err_cnt;
      beat(1'b1, swp(8'h55));
      beat(1'b1, swp(8'h55));
      beat(1'b0, 8'h00);
      drain();
      ex = {};
      chk_frame("gpre_abort", b, e, ex, 0);

      // Back-to-back frames separated by a single dv-low beat
      b = mon_q.size(); e = err_cnt;
      pl = '{8'h11, 8'h22, 8'h33, 8'h44};
      send_giga(2, pl);
      pl = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7};
      send_giga(2, pl);
      drain();
      ex = '{pk(32'h11223344, 1, 1, 2'b00, 0),
             pk(32'hA1A2A3A4, 1, 0, 2'b00, 0),
             pk(32'hA5A6A700, 0, 1, 2'b11, 0)};
      chk_frame("b2b", b, e, ex, 0);

      // Reset after six data bytes while dv stays high, then a full frame
      for (int i = 0; i < 7; i++) beat(1'b1, swp(8'h55));
      beat(1'b1, swp(8'hD5));
      for (int i = 0; i < 6; i++) beat(1'b1, swp(8'(8'hC0 + i)));
      rst = 1'b1;
      #1;
      chk("rstmid_valid", 64'(bus.int_valid_o), 64'd0);
      b = mon_q.size(); e = err_cnt;
      beat(1'b1, swp(8'hC6));
      beat(1'b1, swp(8'hC7));
      rst = 1'b0;
      beat(1'b1, swp(8'hC8));
      beat(1'b1, swp(8'hC9));
      beat(1'b0, 8'h00);
      drain();
      ex = {};
      chk_frame("rstmid", b, e, ex, 0);
      b = mon_q.size(); e = err_cnt;
      pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
      send_giga(7, pl);
      drain();
      ex = '{pk(32'h01020304, 1, 0, 2'b00, 0), pk(32'h05060708, 0, 1, 2'b00, 0)};
      chk_frame("rstnext", b, e, ex, 0);

      chk("idle_zero", 64'(idle_viol), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   // Absolute bound on run time
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

endmodule
